// File: rtl/sum_ascii_sequencer.sv
// Formats a snapshot of the 5-bit operand sum as two ASCII decimal digits and streams the
// bytes to a byte-wide UART with a start/busy handshake. Define SUM_SEQ_CRLF_EN to append CR/LF.
module sum_ascii_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] sum_in,
    input  logic       send_req,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       seq_busy,
    output logic       frame_done,
    output logic       tx_err
);

`ifdef SUM_SEQ_CRLF_EN
    localparam int unsigned IdxW = 2;
`else
    localparam int unsigned IdxW = 1;
`endif
    // The last byte index is all-ones for both frame lengths.
    localparam logic [IdxW-1:0] LastIdx = '1;
    localparam logic [7:0] AckLimit = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWaitAck, StWaitDone} state_e;

    state_e          state_q, state_d;
    logic            send_req_q;
    logic [4:0]      snap_q, snap_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            seq_busy_q, seq_busy_d;
    logic            frame_done_q, frame_done_d;
    logic            tx_err_q, tx_err_d;

    logic       start;
    logic [1:0] tens;
    logic [4:0] tens_x10;
    logic [4:0] ones;
    logic [7:0] cur_byte;

    assign start = send_req & ~send_req_q;

    always_comb begin
        tens     = 2'd0;
        tens_x10 = 5'd0;
        if (snap_q >= 5'd30) begin
            tens     = 2'd3;
            tens_x10 = 5'd30;
        end else if (snap_q >= 5'd20) begin
            tens     = 2'd2;
            tens_x10 = 5'd20;
        end else if (snap_q >= 5'd10) begin
            tens     = 2'd1;
            tens_x10 = 5'd10;
        end
        ones = snap_q - tens_x10;
    end

    always_comb begin
        cur_byte = 8'h30 + {6'd0, tens};
`ifdef SUM_SEQ_CRLF_EN
        case (idx_q)
            2'd0:    cur_byte = 8'h30 + {6'd0, tens};
            2'd1:    cur_byte = 8'h30 + {3'd0, ones};
            2'd2:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
`else
        if (idx_q[0]) begin
            cur_byte = 8'h30 + {3'd0, ones};
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        seq_busy_d   = seq_busy_q;
        frame_done_d = 1'b0;
        tx_err_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    snap_d     = sum_in;
                    idx_d      = '0;
                    seq_busy_d = 1'b1;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (!tx_busy) begin
                    tx_data_d  = cur_byte;
                    tx_start_d = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = StWaitAck;
                end
            end
            StWaitAck: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == AckLimit) begin
                    tx_err_d   = 1'b1;
                    seq_busy_d = 1'b0;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    if (idx_q == LastIdx) begin
                        frame_done_d = 1'b1;
                        seq_busy_d   = 1'b0;
                        state_d      = StIdle;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            send_req_q   <= 1'b0;
            snap_q       <= 5'd0;
            idx_q        <= '0;
            cnt_q        <= 8'd0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            seq_busy_q   <= 1'b0;
            frame_done_q <= 1'b0;
            tx_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            send_req_q   <= send_req;
            snap_q       <= snap_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            seq_busy_q   <= seq_busy_d;
            frame_done_q <= frame_done_d;
            tx_err_q     <= tx_err_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign seq_busy   = seq_busy_q;
    assign frame_done = frame_done_q;
    assign tx_err     = tx_err_q;

endmodule

// File: tb/tb_sum_ascii_sequencer.sv
// Bench for sum_ascii_sequencer: UART busy model, byte monitor and a digit-level reference.
module tb_sum_ascii_sequencer;
    localparam int unsigned ACK_TIMEOUT = 15;
`ifdef SUM_SEQ_CRLF_EN
    localparam int NBytes = 4;
`else
    localparam int NBytes = 2;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] sum_in = 5'd0;
    logic       send_req = 1'b0;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start, seq_busy, frame_done, tx_err;

    logic force_busy = 1'b0;
    logic model_busy = 1'b0;
    logic uart_en = 1'b1;
    int   model_cnt = 0;

    int tests = 0;
    int fails = 0;

    assign tx_busy = model_busy | force_busy;

    sum_ascii_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sum_in     (sum_in),
        .send_req   (send_req),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .seq_busy   (seq_busy),
        .frame_done (frame_done),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART: busy for 10 cycles after each accepted start pulse.
    always @(posedge clk) begin
        if (model_cnt > 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) model_busy <= 1'b0;
        end else if (uart_en && tx_start) begin
            model_busy <= 1'b1;
            model_cnt  <= 10;
        end
    end

    logic [7:0] got[$];
    int n_start = 0, n_done = 0, n_err = 0, n_bad = 0;
    int start_cyc = 0, err_cyc = 0;
    logic prev_start = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (tx_start) begin
            got.push_back(tx_data);
            n_start++;
            start_cyc = cyc;
            if (prev_start) n_bad++;
        end
        if (frame_done) begin
            n_done++;
            if (seq_busy || !prev_busy) n_bad++;
        end
        if (tx_err) begin
            n_err++;
            err_cyc = cyc;
            if (seq_busy || !prev_busy) n_bad++;
        end
        prev_start = tx_start;
        prev_busy  = seq_busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int s, input int b);
        case (b)
            0:       return 8'(48 + s / 10);
            1:       return 8'(48 + s % 10);
            2:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        tick(1);
        send_req = 1'b0;
    endtask

    task automatic run_frame(input logic [4:0] s, input bit lat, input int change_at,
                             input logic [4:0] s2, input bit retrig);
        int bs, bd, be, bq, nb;
        bs = n_start; bd = n_done; be = n_err; bq = got.size();
        sum_in = s;
        pulse_req();
        if (lat) begin
            chk("busy_after_start", 32'(seq_busy), 32'd1);
            tick(1);
            chk("first_start_pulse", 32'(tx_start), 32'd1);
            chk("first_start_data", 32'(tx_data), 32'(exp_byte(int'(s), 0)));
            tick(1);
            chk("start_one_cycle", 32'(tx_start), 32'd0);
        end
        for (int i = 0; i < 800 && n_done == bd && n_err == be; i++) begin
            tick(1);
            if (i == change_at) sum_in = s2;
            if (retrig && i == 20) send_req = 1'b1;
            if (retrig && i == 25) send_req = 1'b0;
        end
        chk("frame_done_count", 32'(n_done - bd), 32'd1);
        chk("no_err_in_frame", 32'(n_err - be), 32'd0);
        chk("start_count", 32'(n_start - bs), 32'(NBytes));
        chk("busy_after_frame", 32'(seq_busy), 32'd0);
        nb = got.size() - bq;
        if (nb > NBytes) nb = NBytes;
        for (int b = 0; b < nb; b++) begin
            chk($sformatf("byte%0d_sum%0d", b, s), 32'(got[bq + b]),
                32'(exp_byte(int'(s), b)));
        end
        tick(3);
    endtask

    initial begin
        int bs, bd, be;
        logic [4:0] r;

        tick(2);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_seq_busy", 32'(seq_busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_tx_err", 32'(tx_err), 32'd0);
        reset_n = 1'b1;
        tick(2);

        run_frame(5'd7, 1'b1, -1, 5'd0, 1'b0);
        run_frame(5'd31, 1'b0, 3, 5'd5, 1'b0);
        run_frame(5'd10, 1'b0, -1, 5'd0, 1'b0);
        run_frame(5'd0, 1'b0, -1, 5'd0, 1'b0);
        run_frame(5'd29, 1'b0, -1, 5'd0, 1'b0);
        repeat (6) begin
            r = 5'($urandom_range(0, 31));
            run_frame(r, 1'b0, 5, 5'($urandom_range(0, 31)), 1'b0);
        end
        // A second rising edge mid-frame must be dropped.
        run_frame(5'($urandom_range(0, 31)), 1'b0, -1, 5'd0, 1'b1);
        run_frame(5'd19, 1'b0, -1, 5'd0, 1'b0);

        // Transmitter never acknowledges.
        uart_en = 1'b0;
        bs = n_start; bd = n_done; be = n_err;
        pulse_req();
        for (int i = 0; i < 100 && n_err == be; i++) tick(1);
        chk("timeout_err_count", 32'(n_err - be), 32'd1);
        chk("timeout_no_done", 32'(n_done - bd), 32'd0);
        chk("timeout_single_start", 32'(n_start - bs), 32'd1);
        chk("timeout_busy_low", 32'(seq_busy), 32'd0);
        chk("timeout_cycles", 32'(err_cyc - start_cyc), 32'(ACK_TIMEOUT));
        uart_en = 1'b1;
        tick(3);

        // Busy held at start withholds tx_start; then reset during WAIT_DONE.
        force_busy = 1'b1;
        bs = n_start;
        sum_in = 5'd22;
        pulse_req();
        tick(8);
        chk("held_busy_no_start", 32'(n_start - bs), 32'd0);
        chk("held_busy_seq_busy", 32'(seq_busy), 32'd1);
        force_busy = 1'b0;
        for (int i = 0; i < 10 && n_start == bs; i++) tick(1);
        chk("released_start", 32'(n_start - bs), 32'd1);
        chk("released_data", 32'(got[got.size() - 1]), 32'h32);
        for (int i = 0; i < 10 && !tx_busy; i++) tick(1);
        tick(2);
        bd = n_done; be = n_err;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_tx_data", 32'(tx_data), 32'h00);
        chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
        chk("mid_rst_seq_busy", 32'(seq_busy), 32'd0);
        chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
        chk("mid_rst_tx_err", 32'(tx_err), 32'd0);
        tick(3);
        reset_n = 1'b1;
        tick(1);
        chk("rst_no_done", 32'(n_done - bd), 32'd0);
        chk("rst_no_err", 32'(n_err - be), 32'd0);
        // Transmitter is still busy from before reset; the frame must wait for it.
        run_frame(5'd14, 1'b0, -1, 5'd0, 1'b0);

        chk("pulse_protocol_errors", 32'(n_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
